// File: rtl/sys_arr_pkg.sv
// -----------------------------------------------------------------------------
// sys_arr_pkg
// Shared definitions for the systolic-array controller:
//   - state_t : controller FSM states (also exported on the debug state output)
//   - cnt_w / beat_w / feed_w / drain_w : counter widths derived from the
//     matrix width M with $clog2
// -----------------------------------------------------------------------------
package sys_arr_pkg;

   localparam int BYTE_W = 8;
   localparam int ELEM_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_FEED   = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_RESULT = 3'd4
   } state_t;

   // Bits needed to hold the values 0..n-1, never less than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Load beat index 0..M-1.
   function automatic int beat_w(input int m);
      return cnt_w(m);
   endfunction

   // Feed beat index 0..3M-3.
   function automatic int feed_w(input int m);
      return cnt_w(3 * m - 2);
   endfunction

   // Drain cycle counter 0..2M+3.
   function automatic int drain_w(input int m);
      return cnt_w(2 * m + 4);
   endfunction

endpackage

// File: rtl/sys_arr_if.sv
// -----------------------------------------------------------------------------
// sys_arr_if
// Bundles the three channels of the controller:
//   load   : in_vld / in_rdy / in_a_row / in_b_col      (environment -> ctrl)
//   array  : arr_rst, arr_vld, arr_rdy, arr_a, arr_b    (ctrl -> array)
//            arr_c, arr_vld_out                         (array -> ctrl)
//   result : res_c / res_vld / res_rdy / res_err        (ctrl -> environment)
//   debug  : dbg_state, the controller's current FSM state
//
// Handshake: a transfer happens on a rising clock edge where both valid and
// ready are 1. Ready never depends on valid in the same cycle. A source holding
// valid keeps its payload stable until the transfer; res_c/res_err stay stable
// while res_vld is 1.
//
// Modports: slave = the controller, master = the surrounding environment.
// -----------------------------------------------------------------------------
interface sys_arr_if #(
   parameter int M = 3
);
   import sys_arr_pkg::*;

   logic                  in_vld;
   logic                  in_rdy;
   logic [8*M-1:0]        in_a_row;
   logic [8*M-1:0]        in_b_col;

   logic                  arr_rst;
   logic                  arr_vld;
   logic                  arr_rdy;
   logic [8*M-1:0]        arr_a;
   logic [8*M-1:0]        arr_b;
   logic [16*M*M-1:0]     arr_c;
   logic                  arr_vld_out;

   logic [16*M*M-1:0]     res_c;
   logic                  res_vld;
   logic                  res_rdy;
   logic                  res_err;

   state_t                dbg_state;

   modport slave (
      input  in_vld, in_a_row, in_b_col, arr_c, arr_vld_out, res_rdy,
      output in_rdy, arr_rst, arr_vld, arr_rdy, arr_a, arr_b,
             res_c, res_vld, res_err, dbg_state
   );

   modport master (
      output in_vld, in_a_row, in_b_col, arr_c, arr_vld_out, res_rdy,
      input  in_rdy, arr_rst, arr_vld, arr_rdy, arr_a, arr_b,
             res_c, res_vld, res_err, dbg_state
   );

endinterface

// File: rtl/sys_arr_skew.sv
// -----------------------------------------------------------------------------
// sys_arr_skew
// Combinational skew network. For feed beat t, lane k carries
//   arr_a lane k = A[k][t-k],  arr_b lane k = B[t-k][k]   when 0 <= t-k < M
// and 0x00 otherwise. Lane 0 sits in the most significant byte.
// Ports:
//   a_buf_i  in  A buffer, a_buf_i[row][col]
//   b_buf_i  in  B buffer, b_buf_i[row][col]
//   t_i      in  feed beat index
//   arr_a_o  out skewed A lanes
//   arr_b_o  out skewed B lanes
// -----------------------------------------------------------------------------
module sys_arr_skew
   import sys_arr_pkg::*;
#(
   parameter int M  = 3,
   parameter int TW = 3
) (
   input  logic [M-1:0][M-1:0][7:0] a_buf_i,
   input  logic [M-1:0][M-1:0][7:0] b_buf_i,
   input  logic [TW-1:0]            t_i,
   output logic [8*M-1:0]           arr_a_o,
   output logic [8*M-1:0]           arr_b_o
);

   localparam int IW = beat_w(M);

   int            idx;
   logic [IW-1:0] ix;

   always_comb begin
      arr_a_o = '0;
      arr_b_o = '0;
      idx     = 0;
      ix      = '0;
      for (int k = 0; k < M; k++) begin
         // Lane k runs k beats behind lane 0.
         idx = int'(t_i) - k;
         ix  = idx[IW-1:0];
         if ((idx >= 0) && (idx < M)) begin
            arr_a_o[8*(M-1-k) +: 8] = a_buf_i[k][ix];
            arr_b_o[8*(M-1-k) +: 8] = b_buf_i[ix][k];
         end
      end
   end

endmodule

// File: rtl/sys_arr_ctrl.sv
// -----------------------------------------------------------------------------
// sys_arr_ctrl
// Controller for an MxM systolic multiplier array. Collects M load beats
// (row r of A and column r of B per beat), streams the operands into the array
// with the diagonal skew, waits for the array result and presents it on the
// result channel. If the array stays silent for 2M+4 drain cycles, a zero
// result flagged with res_err is presented instead.
// Ports:
//   CLK    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    sys_arr_if.slave : load, array and result channels plus dbg_state
// -----------------------------------------------------------------------------
module sys_arr_ctrl
   import sys_arr_pkg::*;
#(
   parameter int M = 3
) (
   input logic      CLK,
   input logic      rst_n,
   sys_arr_if.slave bus
);

   localparam int BW = beat_w(M);
   localparam int TW = feed_w(M);
   localparam int DW = drain_w(M);

   localparam logic [BW-1:0] BEAT_LAST = BW'(M - 1);
   localparam logic [TW-1:0] T_LAST    = TW'(3 * M - 3);
   localparam logic [DW-1:0] D_LAST    = DW'(2 * M + 3);

   state_t                   state_q, state_d;
   logic [BW-1:0]            beat_q, beat_d;
   logic [TW-1:0]            t_q, t_d;
   logic [DW-1:0]            dcnt_q, dcnt_d;
   logic [M-1:0][M-1:0][7:0] a_buf_q, a_buf_d;
   logic [M-1:0][M-1:0][7:0] b_buf_q, b_buf_d;
   logic [16*M*M-1:0]        res_c_q, res_c_d;
   logic                     res_err_q, res_err_d;
   logic                     arr_rst_q, arr_rst_d;
   logic                     arr_vld_q, arr_vld_d;

   logic                     load_en;
   logic                     accept;
   logic [8*M-1:0]           skew_a, skew_b;

   assign load_en = (state_q == ST_IDLE) || (state_q == ST_LOAD);
   // in_rdy is also gated by rst_n so it reads 0 while reset is held.
   assign accept  = load_en && rst_n && bus.in_vld;

   // -------------------------------------------------------------------------
   // State register (also holds counters, buffers and registered outputs)
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         beat_q    <= '0;
         t_q       <= '0;
         dcnt_q    <= '0;
         a_buf_q   <= '0;
         b_buf_q   <= '0;
         res_c_q   <= '0;
         res_err_q <= 1'b0;
         arr_rst_q <= 1'b1;
         arr_vld_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         t_q       <= t_d;
         dcnt_q    <= dcnt_d;
         a_buf_q   <= a_buf_d;
         b_buf_q   <= b_buf_d;
         res_c_q   <= res_c_d;
         res_err_q <= res_err_d;
         arr_rst_q <= arr_rst_d;
         arr_vld_q <= arr_vld_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      t_d       = t_q;
      dcnt_d    = dcnt_q;
      a_buf_d   = a_buf_q;
      b_buf_d   = b_buf_q;
      res_c_d   = res_c_q;
      res_err_d = res_err_q;

      unique case (state_q)
         ST_IDLE, ST_LOAD: begin
            t_d = '0;
            if (accept) begin
               a_buf_d[beat_q] = bus.in_a_row;
               // Beat r carries column r of B; element k is B[k][r].
               for (int k = 0; k < M; k++) begin
                  b_buf_d[k][beat_q] = bus.in_b_col[8*k +: 8];
               end
               if (beat_q == BEAT_LAST) begin
                  beat_d  = '0;
                  state_d = ST_FEED;
               end else begin
                  beat_d  = beat_q + BW'(1);
                  state_d = ST_LOAD;
               end
            end
         end

         ST_FEED: begin
            dcnt_d = '0;
            if (bus.arr_vld_out) begin
               res_c_d   = bus.arr_c;
               res_err_d = 1'b0;
               state_d   = ST_RESULT;
            end else if (t_q == T_LAST) begin
               state_d = ST_DRAIN;
            end else begin
               t_d = t_q + TW'(1);
            end
         end

         ST_DRAIN: begin
            if (bus.arr_vld_out) begin
               res_c_d   = bus.arr_c;
               res_err_d = 1'b0;
               state_d   = ST_RESULT;
            end else if (dcnt_q == D_LAST) begin
               // Array never answered: report a zero result flagged as error.
               res_c_d   = '0;
               res_err_d = 1'b1;
               state_d   = ST_RESULT;
            end else begin
               dcnt_d = dcnt_q + DW'(1);
            end
         end

         ST_RESULT: begin
            if (bus.res_rdy) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Output logic
   // -------------------------------------------------------------------------
   always_comb begin
      // Array control is registered, so it is decoded from the next state.
      arr_rst_d   = (state_d == ST_IDLE) || (state_d == ST_LOAD);
      arr_vld_d   = (state_d == ST_FEED) || (state_d == ST_DRAIN);
      bus.in_rdy  = load_en && rst_n;
      bus.res_vld = (state_q == ST_RESULT);
      bus.arr_a   = (state_q == ST_FEED) ? skew_a : '0;
      bus.arr_b   = (state_q == ST_FEED) ? skew_b : '0;
   end

   assign bus.arr_rst   = arr_rst_q;
   assign bus.arr_vld   = arr_vld_q;
   assign bus.arr_rdy   = arr_vld_q;
   assign bus.res_c     = res_c_q;
   assign bus.res_err   = res_err_q;
   assign bus.dbg_state = state_q;

   sys_arr_skew #(
      .M  (M),
      .TW (TW)
   ) u_skew (
      .a_buf_i (a_buf_q),
      .b_buf_i (b_buf_q),
      .t_i     (t_q),
      .arr_a_o (skew_a),
      .arr_b_o (skew_b)
   );

endmodule

// File: tb/tb_sys_arr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sys_arr_ctrl
// Drives sys_arr_ctrl (M = 3) through directed and random matrix jobs. A small
// behavioural array model turns the observed skewed lanes into a product that
// is fed back on arr_c; the expected result is the plain matrix product A*B
// (mod 2^16) held in a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_sys_arr_ctrl;
   import sys_arr_pkg::*;

   localparam int M  = 3;
   localparam int NF = 3 * M - 2;   // feed beats
   localparam int ND = 2 * M + 4;   // drain cycles before timeout
   localparam int CW = 16 * M * M;

   // ---------------- clock / reset ----------------
   logic CLK   = 1'b0;
   logic rst_n = 1'b0;
   always #5 CLK = ~CLK;

   sys_arr_if #(.M(M)) bus ();

   sys_arr_ctrl #(.M(M)) dut (
      .CLK   (CLK),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- bookkeeping ----------------
   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0]    ma    [M][M];
   logic [7:0]    mb    [M][M];
   logic [7:0]    obs_a [NF][M];
   logic [7:0]    obs_b [NF][M];
   logic [CW-1:0] exp_q [$];

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected lane vector for feed beat t.
   function automatic logic [8*M-1:0] lane_vec(input bit is_a, input int t);
      logic [8*M-1:0] v;
      v = '0;
      for (int k = 0; k < M; k++) begin
         if ((t - k >= 0) && (t - k < M)) begin
            v[8*(M-1-k) +: 8] = is_a ? ma[k][t-k] : mb[t-k][k];
         end
      end
      return v;
   endfunction

   // Plain matrix product, 16-bit wrap.
   function automatic logic [CW-1:0] matmul();
      logic [CW-1:0] c;
      int            acc;
      c = '0;
      for (int i = 0; i < M; i++) begin
         for (int j = 0; j < M; j++) begin
            acc = 0;
            for (int k = 0; k < M; k++) acc += ma[i][k] * mb[k][j];
            c[16*(i*M+j) +: 16] = 16'(acc);
         end
      end
      return c;
   endfunction

   // Array model: PE(i,j) sees A lane i delayed by j and B lane j delayed by i.
   function automatic logic [CW-1:0] array_model();
      logic [CW-1:0] c;
      int            acc;
      int            ta;
      int            tb;
      c = '0;
      for (int i = 0; i < M; i++) begin
         for (int j = 0; j < M; j++) begin
            acc = 0;
            for (int s = 0; s < NF + 2 * M; s++) begin
               ta = s - j;
               tb = s - i;
               if ((ta >= 0) && (ta < NF) && (tb >= 0) && (tb < NF)) begin
                  acc += obs_a[ta][i] * obs_b[tb][j];
               end
            end
            c[16*(i*M+j) +: 16] = 16'(acc);
         end
      end
      return c;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic junk_inputs();
      bus.in_vld = 1'b1;
      for (int k = 0; k < M; k++) begin
         bus.in_a_row[8*k +: 8] = 8'($urandom);
         bus.in_b_col[8*k +: 8] = 8'($urandom);
      end
   endtask

   task automatic junk_arr_c();
      for (int w = 0; w < M * M; w++) bus.arr_c[16*w +: 16] = 16'($urandom);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_in_rdy"},  bus.in_rdy,  0);
      chk({tag, "_arr_rst"}, bus.arr_rst, 1);
      chk({tag, "_arr_vld"}, bus.arr_vld, 0);
      chk({tag, "_arr_rdy"}, bus.arr_rdy, 0);
      chk({tag, "_arr_a"},   bus.arr_a,   0);
      chk({tag, "_arr_b"},   bus.arr_b,   0);
      chk({tag, "_res_vld"}, bus.res_vld, 0);
      chk({tag, "_res_err"}, bus.res_err, 0);
      chk({tag, "_res_c"},   bus.res_c,   0);
   endtask

   task automatic rand_mats();
      for (int i = 0; i < M; i++) begin
         for (int j = 0; j < M; j++) begin
            ma[i][j] = 8'($urandom);
            mb[i][j] = 8'($urandom);
         end
      end
   endtask

   // mode 0: array answers after dly drain cycles
   // mode 1: array never answers (timeout)
   // mode 2: array answers, res_rdy held low 10 cycles
   // mode 3: reset pulsed during feed beat 3
   task automatic run_job(input int mode, input int dly);
      logic [CW-1:0] exp_v;
      int            r;
      int            hold;
      if (mode == 1) exp_q.push_back('0);
      else if (mode != 3) exp_q.push_back(matmul());

      // load phase, with a few idle gaps early on
      r = 0;
      for (int it = 0; (it < 3 * M) && (r < M); it++) begin
         @(negedge CLK);
         chk("load_in_rdy",  bus.in_rdy,  1);
         chk("load_arr_rst", bus.arr_rst, 1);
         chk("load_arr_vld", bus.arr_vld, 0);
         // array result outside feed/drain must be ignored
         bus.arr_vld_out = 1'($urandom_range(0, 1));
         junk_arr_c();
         if ((it < 2 * M) && ($urandom_range(0, 3) == 0)) begin
            bus.in_vld = 1'b0;
         end else begin
            bus.in_vld = 1'b1;
            for (int k = 0; k < M; k++) begin
               bus.in_a_row[8*k +: 8] = ma[r][k];
               bus.in_b_col[8*k +: 8] = mb[k][r];
            end
            r++;
         end
      end

      // feed phase
      for (int t = 0; t < NF; t++) begin
         @(negedge CLK);
         chk("feed_state",   bus.dbg_state, ST_FEED);
         chk("feed_in_rdy",  bus.in_rdy,  0);
         chk("feed_arr_rst", bus.arr_rst, 0);
         chk("feed_vld_rdy", {bus.arr_vld, bus.arr_rdy}, 2'b11);
         chk("feed_arr_a",   bus.arr_a, lane_vec(1'b1, t));
         chk("feed_arr_b",   bus.arr_b, lane_vec(1'b0, t));
         for (int k = 0; k < M; k++) begin
            obs_a[t][k] = bus.arr_a[8*(M-1-k) +: 8];
            obs_b[t][k] = bus.arr_b[8*(M-1-k) +: 8];
         end
         if ((mode == 3) && (t == 3)) begin
            rst_n = 1'b0;
            #1;
            reset_checks("abort");
            chk("abort_state", bus.dbg_state, ST_IDLE);
            bus.in_vld      = 1'b0;
            bus.arr_vld_out = 1'b0;
            @(negedge CLK);
            rst_n = 1'b1;
            return;
         end
         bus.arr_vld_out = 1'b0;
         junk_inputs();
      end

      // drain phase
      for (int d = 0; d < ND; d++) begin
         @(negedge CLK);
         chk("drain_state",   bus.dbg_state, ST_DRAIN);
         chk("drain_vld_rdy", {bus.arr_vld, bus.arr_rdy}, 2'b11);
         chk("drain_arr_ab",  {bus.arr_a, bus.arr_b}, 0);
         chk("drain_res_vld", bus.res_vld, 0);
         chk("drain_in_rdy",  bus.in_rdy, 0);
         junk_inputs();
         if ((mode != 1) && (d == dly)) begin
            bus.arr_c       = array_model();
            bus.arr_vld_out = 1'b1;
            break;
         end
      end

      // result phase
      @(negedge CLK);
      exp_v = exp_q.pop_front();
      chk("res_state",   bus.dbg_state, ST_RESULT);
      chk("res_vld",     bus.res_vld, 1);
      chk("res_c",       bus.res_c, exp_v);
      chk("res_err",     bus.res_err, (mode == 1));
      chk("res_in_rdy",  bus.in_rdy, 0);
      chk("res_arr_vld", {bus.arr_vld, bus.arr_rdy, bus.arr_rst}, 3'b000);
      chk("res_arr_ab",  {bus.arr_a, bus.arr_b}, 0);
      hold = (mode == 2) ? 10 : $urandom_range(0, 2);
      for (int h = 0; h < hold; h++) begin
         bus.res_rdy     = 1'b0;
         bus.arr_vld_out = 1'b1;
         junk_arr_c();
         junk_inputs();
         @(negedge CLK);
         chk("hold_res_vld", bus.res_vld, 1);
         chk("hold_res_c",   bus.res_c, exp_v);
         chk("hold_res_err", bus.res_err, (mode == 1));
         chk("hold_in_rdy",  bus.in_rdy, 0);
      end
      // in_vld stays high across the exit cycle; that beat must not be taken
      bus.res_rdy = 1'b1;
      junk_inputs();
      @(negedge CLK);
      chk("exit_state",   bus.dbg_state, ST_IDLE);
      chk("exit_res_vld", bus.res_vld, 0);
      chk("exit_in_rdy",  bus.in_rdy, 1);
      bus.res_rdy     = 1'b0;
      bus.in_vld      = 1'b0;
      bus.arr_vld_out = 1'b0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      bus.in_vld      = 1'b0;
      bus.in_a_row    = '0;
      bus.in_b_col    = '0;
      bus.arr_c       = '0;
      bus.arr_vld_out = 1'b0;
      bus.res_rdy     = 1'b0;
      rst_n           = 1'b0;

      repeat (2) @(negedge CLK);
      reset_checks("rst");
      chk("rst_state", bus.dbg_state, ST_IDLE);
      rst_n = 1'b1;
      #1;
      chk("rst_rel_in_rdy", bus.in_rdy, 1);

      // A = identity, B = 1..9 row-major: result equals B
      for (int i = 0; i < M; i++) begin
         for (int j = 0; j < M; j++) begin
            ma[i][j] = (i == j) ? 8'd1 : 8'd0;
            mb[i][j] = 8'(i * M + j + 1);
         end
      end
      run_job(0, $urandom_range(0, ND - 1));

      // all 2: every element 12
      for (int i = 0; i < M; i++) begin
         for (int j = 0; j < M; j++) begin
            ma[i][j] = 8'd2;
            mb[i][j] = 8'd2;
         end
      end
      run_job(0, $urandom_range(0, ND - 1));

      // all 255: every element 64003
      for (int i = 0; i < M; i++) begin
         for (int j = 0; j < M; j++) begin
            ma[i][j] = 8'd255;
            mb[i][j] = 8'd255;
         end
      end
      run_job(0, ND - 1);

      // result back-pressure
      rand_mats();
      run_job(2, $urandom_range(0, ND - 1));

      // array timeout
      rand_mats();
      run_job(1, 0);

      // reset mid-feed, then a fresh job
      rand_mats();
      run_job(3, 0);
      rand_mats();
      run_job(0, $urandom_range(0, ND - 1));

      // random jobs
      for (int n = 0; n < 4; n++) begin
         rand_mats();
         run_job(0, $urandom_range(0, ND - 1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/sys_arr_ctrl.md
SYS_ARR_CTRL -- requirements
Module: sys_arr_ctrl

Interface
REQ-001 SHALL have parameter M, default 3, giving the square matrix width (M >= 2).
REQ-002 SHALL have port CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_vld  in  1  load beat valid.
REQ-005 SHALL have port in_rdy  out  1  load beat accepted when in_vld && in_rdy.
REQ-006 SHALL have port in_a_row  in  8*M  row r of A; element k at bits [8k+7:8k].
REQ-007 SHALL have port in_b_col  in  8*M  column r of B; element k at bits [8k+7:8k].
REQ-008 SHALL have port arr_rst  out  1  synchronous active-high clear to array.
REQ-009 SHALL have port arr_vld  out  1  drives array vld_in.
REQ-010 SHALL have port arr_rdy  out  1  drives array rdy_out; always equals arr_vld.
REQ-011 SHALL have port arr_a  out  8*M  skewed A lanes; lane 0 in MSB byte [8M-1:8M-8].
REQ-012 SHALL have port arr_b  out  8*M  skewed B lanes; lane 0 in MSB byte.
REQ-013 SHALL have port arr_c  in  16*M*M  array result bus.
REQ-014 SHALL have port arr_vld_out  in  1  array result valid.
REQ-015 SHALL have port res_c  out  16*M*M  captured result.
REQ-016 SHALL have port res_vld  out  1  result valid.
REQ-017 SHALL have port res_rdy  in  1  result consumed when res_vld && res_rdy.
REQ-018 SHALL have port res_err  out  1  qualifies res_vld; 1 = array timeout.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, FEED, DRAIN, RESULT.
REQ-020 SHALL assert in_rdy only in IDLE and LOAD; accepted beat r (0..M-1) stored into A row r and B column r of internal buffers.
REQ-021 SHALL move IDLE->LOAD on first accepted beat, and LOAD->FEED on the accepted beat with r = M-1 (a single beat with M=... never skips LOAD semantics; beat counter wraps to 0).
REQ-022 SHALL drive arr_rst = 1 in IDLE and LOAD, 0 in FEED, DRAIN and RESULT, all registered.
REQ-023 SHALL drive arr_vld = arr_rdy = 1 in FEED and DRAIN only.
REQ-024 SHALL, in FEED beat t = 0..3M-3, drive lane k of arr_a = A[k][t-k] and lane k of arr_b = B[t-k][k] when 0 <= t-k < M, else 0x00.
REQ-025 SHALL move FEED->DRAIN after beat t = 3M-3; arr_a = arr_b = 0 outside FEED.
REQ-026 SHALL, in FEED or DRAIN, on any cycle with arr_vld_out = 1, capture arr_c into res_c, set res_err = 0 and enter RESULT.
REQ-027 SHALL, in DRAIN, count cycles; if 2M+4 DRAIN cycles pass without arr_vld_out, enter RESULT with res_c = 0 and res_err = 1.
REQ-028 SHALL hold res_vld = 1 and res_c, res_err stable throughout RESULT; RESULT->IDLE on res_vld && res_rdy.
REQ-029 SHALL ignore arr_vld_out outside FEED/DRAIN and in_vld outside IDLE/LOAD (in_rdy = 0 there).
REQ-030 SHALL NOT accept a load beat in the cycle RESULT exits; next accept earliest in following IDLE cycle.
REQ-031 SHALL pass arr_c element widths unchanged (16-bit, mod 2^16 as produced by the array).

Reset
REQ-032 SHALL, while rst_n = 0, force state IDLE, all counters 0, buffers 0, in_rdy 0 on the reset cycle then per REQ-020, arr_rst 1, arr_vld 0, arr_rdy 0, arr_a 0, arr_b 0, res_vld 0, res_err 0, res_c 0.
REQ-033 SHALL abandon any in-progress job when rst_n asserts mid-operation; no partial result is ever presented.

Structure
REQ-034 SHALL place the FSM state enum and width helpers (beat/counter widths from $clog2) in a shared package sys_arr_pkg.
REQ-035 SHALL contain one sub-module, sys_arr_skew, producing arr_a/arr_b combinationally from buffers and beat index t.

Verification (M = 3)
REQ-036 A = identity, B = 1..9 row-major -> res_c equals B, res_err = 0.
REQ-037 A = B = all 2 -> every res_c element = 12.
REQ-038 A = B = all 255 -> every element = 195075 mod 65536 = 64003.
REQ-039 res_rdy held 0 for 10 cycles in RESULT -> res_vld, res_c stable; in_rdy = 0 throughout.
REQ-040 arr_vld_out tied 0 -> RESULT after 7 FEED + 10 DRAIN cycles with res_err = 1, res_c = 0.
REQ-041 rst_n pulsed low during FEED beat 3 -> all outputs at reset values immediately; fresh job then completes correctly.
